// File: rtl/sample_frame_buffer.sv
// Ping-pong input frame buffer: streams samples into two FRAME_LEN-deep banks and
// offers each completed bank for random-access reads until it is released.
module sample_frame_buffer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 48,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              input_ena,
    output logic [CNT_W-1:0]  wr_count,
    output logic              frame_done,
    output logic              frame_avail,
    input  logic              rd_en,
    input  logic [CNT_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              frame_release,
    output logic              overflow
);

    localparam int               AW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FRAME_LEN);

    logic [DATA_W-1:0] mem [2][FRAME_LEN];

    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_ptr;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;
    logic             accept;
    logic             wr_last;
    logic             release_hit;
    logic             rd_hit;

    assign sample_ready = ~bank_full[wr_bank];
    assign accept       = sample_valid & sample_ready;
    assign input_ena    = accept;
    assign wr_count     = wr_ptr;
    assign frame_avail  = bank_full[rd_bank];
    assign wr_last      = accept & (wr_ptr == LAST_IDX);
    assign release_hit  = frame_release & frame_avail;
    assign rd_hit       = rd_en & frame_avail & (rd_addr < DEPTH);

    // Completion and release can never target the same bank: one needs it empty,
    // the other needs it full, so both updates apply independently.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (release_hit) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_ptr     <= '0;
            bank_full  <= 2'b00;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            bank_full  <= bank_full_nxt;
            frame_done <= wr_last;
            if (sample_valid && !sample_ready) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + CNT_W'(1);
                end
            end
            if (release_hit) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Bank storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (n_reset && accept) begin
            mem[wr_bank][wr_ptr[AW-1:0]] <= sample_in;
        end
    end

    // Uses the pre-release rd_bank, so a read issued alongside a release sees the old bank.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_data <= mem[rd_bank][rd_addr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer: stimulus pushes expected read data and
// frame_done events, a negedge monitor pops and compares them.
module tb_sample_frame_buffer;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        input_ena;
    logic [6:0]  wr_count;
    logic        frame_done;
    logic        frame_avail;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_release;
    logic        overflow;

    int          vectors = 0;
    int          errors  = 0;
    int          m_ptr   = 0;
    logic [15:0] exp_rd_q[$];
    int          exp_done_q[$];

    sample_frame_buffer dut (
        .clk(clk),
        .n_reset(n_reset),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .input_ena(input_ena),
        .wr_count(wr_count),
        .frame_done(frame_done),
        .frame_avail(frame_avail),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .frame_release(frame_release),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                chk("rd_valid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rd_data", {16'd0, rd_data}, {16'd0, exp_rd_q.pop_front()});
            end
        end
        if (frame_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                chk("frame_done_unexpected", 32'd1, 32'd0);
            end else begin
                void'(exp_done_q.pop_front());
                vectors++;
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send(input logic [15:0] v, input bit acc, input bit rel);
        sample_in     = v;
        sample_valid  = 1'b1;
        frame_release = rel;
        #1;
        chk("input_ena", {31'd0, input_ena}, {31'd0, acc});
        if (acc) begin
            m_ptr++;
            if (m_ptr == 48) begin
                m_ptr = 0;
                exp_done_q.push_back(1);
            end
        end
        @(posedge clk);
        #1;
        sample_valid  = 1'b0;
        frame_release = 1'b0;
    endtask

    task automatic stream(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            send(16'(base + i), 1'b1, 1'b0);
        end
    endtask

    task automatic rd(input int addr, input bit hit, input logic [15:0] exp, input bit rel);
        rd_en         = 1'b1;
        rd_addr       = 7'(addr);
        frame_release = rel;
        if (hit) exp_rd_q.push_back(exp);
        @(posedge clk);
        #1;
        rd_en         = 1'b0;
        frame_release = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_reset       = 1'b0;
        sample_in     = '0;
        sample_valid  = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        frame_release = 1'b0;
        idle();
        idle();
        chk("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst_wr_count", {25'd0, wr_count}, 32'd0);
        chk("rst_frame_avail", {31'd0, frame_avail}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        n_reset = 1'b1;
        idle();

        // First frame, back-to-back
        stream(0, 48);
        chk("f0_frame_done", {31'd0, frame_done}, 32'd1);
        chk("f0_frame_avail", {31'd0, frame_avail}, 32'd1);
        chk("f0_wr_count", {25'd0, wr_count}, 32'd0);
        for (int i = 0; i < 48; i++) rd(i, 1'b1, 16'(i), 1'b0);

        // Second frame fills both banks
        stream(48, 20);
        chk("f1_wr_count", {25'd0, wr_count}, 32'd20);
        stream(68, 28);
        chk("full_sample_ready", {31'd0, sample_ready}, 32'd0);
        send(16'd999, 1'b0, 1'b0);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_wr_count", {25'd0, wr_count}, 32'd0);

        // Release of bank 0: ready only rises after the edge
        frame_release = 1'b1;
        #1;
        chk("rel_ready_comb", {31'd0, sample_ready}, 32'd0);
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        chk("rel_frame_avail", {31'd0, frame_avail}, 32'd1);
        chk("rel_sample_ready", {31'd0, sample_ready}, 32'd1);
        for (int i = 0; i < 48; i++) rd(i, 1'b1, 16'(48 + i), 1'b0);

        // Out-of-range address on a full bank
        rd(50, 1'b0, 16'd0, 1'b0);
        chk("oor_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("oor_rd_data", {16'd0, rd_data}, 32'd95);

        // Frame completion and release on the same edge
        stream(100, 47);
        send(16'd147, 1'b1, 1'b1);
        chk("sim_frame_done", {31'd0, frame_done}, 32'd1);
        chk("sim_frame_avail", {31'd0, frame_avail}, 32'd1);
        chk("sim_sample_ready", {31'd0, sample_ready}, 32'd1);
        rd(0, 1'b1, 16'd100, 1'b0);
        rd(47, 1'b1, 16'd147, 1'b0);
        rd(5, 1'b1, 16'd105, 1'b1);
        chk("rdrel_frame_avail", {31'd0, frame_avail}, 32'd0);

        // Read and release with no full bank
        rd(3, 1'b0, 16'd0, 1'b1);
        chk("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("empty_rd_data", {16'd0, rd_data}, 32'd105);
        chk("empty_frame_avail", {31'd0, frame_avail}, 32'd0);
        chk("empty_sample_ready", {31'd0, sample_ready}, 32'd1);

        // Reset mid-frame
        stream(200, 20);
        chk("mid_wr_count", {25'd0, wr_count}, 32'd20);
        n_reset = 1'b0;
        m_ptr   = 0;
        idle();
        chk("mrst_wr_count", {25'd0, wr_count}, 32'd0);
        chk("mrst_frame_avail", {31'd0, frame_avail}, 32'd0);
        chk("mrst_overflow", {31'd0, overflow}, 32'd0);
        n_reset = 1'b1;
        idle();
        stream(300, 48);
        chk("post_frame_done", {31'd0, frame_done}, 32'd1);
        chk("post_frame_avail", {31'd0, frame_avail}, 32'd1);
        rd(0, 1'b1, 16'd300, 1'b0);
        rd(19, 1'b1, 16'd319, 1'b0);
        rd(20, 1'b1, 16'd320, 1'b0);
        rd(47, 1'b1, 16'd347, 1'b0);

        idle();
        idle();
        chk("rd_queue_drained", exp_rd_q.size(), 32'd0);
        chk("done_queue_drained", exp_done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
